// File: rtl/event_buf_pkg.sv
// Shared event-buffer parameters and read-side FSM encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package event_buf_pkg;

    localparam int EB_DATA_W    = 16;
    localparam int EB_WORD_W    = 4;
    localparam int EB_EPTR_W    = 6;
    localparam int EB_EVT_WORDS = 1 << EB_WORD_W;
    localparam int EB_ADDR_W    = EB_EPTR_W + EB_WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SUBMIT = 2'd1,
        ST_READ   = 2'd2,
        ST_DRAIN  = 2'd3
    } evt_rd_state_t;

endpackage

// File: rtl/read_skid_fifo.sv
// Small synchronous FIFO catching RAM read data ahead of the output stream.
// Latency: one cycle from write to valid at the head.
// Backpressure: none internally; the writer must respect count (credit based).
module read_skid_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign valid   = (count != '0);
    assign rd_data = mem[rd_ptr];
    assign do_wr   = wr_en && !flush;
    assign do_rd   = rd_en && valid && !flush;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage array: written only, never reset (head is qualified by valid).
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

endmodule

// File: rtl/event_read_control.sv
// Claims one queued event, reads its words from the buffer RAM and streams them with sof/eof.
// Latency: r_request sampled to first o_valid is 3 + RD_LAT cycles; one word/cycle sustained.
// Backpressure: o_ready stalls the skid FIFO; RAM reads are credit-limited so it never overflows.
module event_read_control
    import event_buf_pkg::*;
#(
    parameter int DATA_W     = EB_DATA_W,
    parameter int WORD_W     = EB_WORD_W,
    parameter int EPTR_W     = EB_EPTR_W,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     live_rising,
    input  logic                     r_request,
    output logic                     r_submit,
    output logic                     mem_rd_en,
    output logic [EPTR_W+WORD_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic                     o_sof,
    output logic                     o_eof,
    output logic                     rd_done,
    output logic                     busy,
    output logic [15:0]              evt_count
);

    localparam int EVT_WORDS = 1 << WORD_W;
    localparam int FW        = DATA_W + 2;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

    evt_rd_state_t     state;
    evt_rd_state_t     state_nxt;
    logic [EPTR_W-1:0] evt_ptr;
    logic [WORD_W-1:0] word_idx;
    logic [RD_LAT-1:0] sr_vld;
    logic [RD_LAT-1:0] sr_sof;
    logic [RD_LAT-1:0] sr_eof;
    logic [7:0]        inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_vld;
    logic [FW-1:0]     fifo_head;
    logic              credit;
    logic              last_word;
    logic              eof_accept;

    assign last_word   = (word_idx == WORD_W'(EVT_WORDS - 1));
    assign mem_rd_addr = {evt_ptr, word_idx};
    assign busy        = (state != ST_IDLE);

    // Reads outstanding in the RAM latency pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 8'(sr_vld[i]);
        end
    end

    assign credit = (8'(fifo_count) + inflight) < 8'(FIFO_DEPTH);

    // Output head is zeroed when empty so all stream outputs read 0 in reset.
    assign o_valid    = fifo_vld;
    assign o_data     = fifo_vld ? fifo_head[DATA_W-1:0] : '0;
    assign o_sof      = fifo_vld && fifo_head[DATA_W+1];
    assign o_eof      = fifo_vld && fifo_head[DATA_W];
    assign eof_accept = o_valid && o_ready && o_eof;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and strobes; a run-start flush overrides everything.
    always_comb begin
        state_nxt = state;
        r_submit  = 1'b0;
        mem_rd_en = 1'b0;
        rd_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (r_request) state_nxt = ST_SUBMIT;
            end
            ST_SUBMIT: begin
                r_submit  = 1'b1;
                state_nxt = ST_READ;
            end
            ST_READ: begin
                if (credit) begin
                    mem_rd_en = 1'b1;
                    if (last_word) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (eof_accept) begin
                    rd_done   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (live_rising) begin
            state_nxt = ST_IDLE;
            r_submit  = 1'b0;
            mem_rd_en = 1'b0;
            rd_done   = 1'b0;
        end
    end

    // Event pointer, word index and completed-event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_ptr   <= '0;
            word_idx  <= '0;
            evt_count <= '0;
        end else if (live_rising) begin
            evt_ptr   <= '0;
            word_idx  <= '0;
            evt_count <= '0;
        end else begin
            if (state == ST_SUBMIT) word_idx <= '0;
            else if (mem_rd_en)     word_idx <= word_idx + WORD_W'(1);
            if (rd_done) begin
                evt_ptr   <= evt_ptr + EPTR_W'(1);
                evt_count <= evt_count + 16'd1;
            end
        end
    end

    // Read-latency pipeline: tags each issued read until its data returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_vld <= '0;
            sr_sof <= '0;
            sr_eof <= '0;
        end else if (live_rising) begin
            sr_vld <= '0;
            sr_sof <= '0;
            sr_eof <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                sr_vld[i] <= sr_vld[i-1];
                sr_sof[i] <= sr_sof[i-1];
                sr_eof[i] <= sr_eof[i-1];
            end
            sr_vld[0] <= mem_rd_en;
            sr_sof[0] <= mem_rd_en && (word_idx == '0);
            sr_eof[0] <= mem_rd_en && last_word;
        end
    end

    read_skid_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (live_rising),
        .wr_en   (sr_vld[RD_LAT-1]),
        .wr_data ({sr_sof[RD_LAT-1], sr_eof[RD_LAT-1], mem_rd_data}),
        .rd_en   (o_ready),
        .rd_data (fifo_head),
        .valid   (fifo_vld),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_event_read_control.sv
// Randomized bench for event_read_control with RAM, queue and stream reference models.
// Latency: checks the 5-cycle request-to-valid figure at defaults.
// Backpressure: drives o_ready always-on, 1,0,0,1 pattern, or random 70%.
module tb_event_read_control;

    localparam int DATA_W     = 16;
    localparam int WORD_W     = 4;
    localparam int EPTR_W     = 6;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int EVT_WORDS  = 1 << WORD_W;
    localparam int SLOTS      = 1 << EPTR_W;
    localparam int ADDR_W     = EPTR_W + WORD_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              live_rising;
    logic              r_request;
    logic              r_submit;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_ready;
    logic              o_sof;
    logic              o_eof;
    logic              rd_done;
    logic              busy;
    logic [15:0]       evt_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    event_read_control #(
        .DATA_W(DATA_W), .WORD_W(WORD_W), .EPTR_W(EPTR_W),
        .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .live_rising(live_rising),
        .r_request(r_request), .r_submit(r_submit),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
        .o_sof(o_sof), .o_eof(o_eof), .rd_done(rd_done),
        .busy(busy), .evt_count(evt_count)
    );

    task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // RAM model: every word holds its own address, returned RD_LAT cycles later.
    logic [ADDR_W-1:0] ram_pipe [RD_LAT];
    always @(posedge clk) begin
        ram_pipe[0] <= mem_rd_addr;
        for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign mem_rd_data = DATA_W'(ram_pipe[RD_LAT-1]);

    // Reference state: queue model, expected stream position, counters.
    int           posted = 0;
    int           q_sub = 0;
    int           exp_evt = 0;
    int           exp_word = 0;
    int           issued = 0;
    int           accepted = 0;
    int           words_total = 0;
    int           eofs_total = 0;
    int           ev64_eof_data = -1;
    int           last_sof_data = -1;
    bit           mon_en = 0;
    bit           prev_stall = 0;
    logic [17:0]  prev_word = '0;
    int           rdy_mode = 0;
    int           rdy_phase = 0;

    // Monitor / scoreboard sampling on the falling edge; also models the queue controller.
    always @(negedge clk) begin
        if (r_submit) q_sub = q_sub + 1;
        r_request = (posted > q_sub);
        if (!rst_n || !mon_en || live_rising) begin
            exp_evt = 0; exp_word = 0; issued = 0; accepted = 0; prev_stall = 0;
        end else begin
            if (prev_stall) begin
                expect_eq("stall_valid", 32'(o_valid), 32'd1);
                expect_eq("stall_word", 32'({o_sof, o_eof, o_data}), 32'(prev_word));
            end
            if (o_valid && o_ready) begin
                expect_eq("data", 32'(o_data), 32'((exp_evt % SLOTS) * EVT_WORDS + exp_word));
                expect_eq("sof", 32'(o_sof), 32'(exp_word == 0));
                expect_eq("eof", 32'(o_eof), 32'(exp_word == EVT_WORDS - 1));
                expect_eq("rd_done", 32'(rd_done), 32'(exp_word == EVT_WORDS - 1));
                if (o_sof) last_sof_data = int'(o_data);
                accepted = accepted + 1;
                words_total = words_total + 1;
                if (exp_word == EVT_WORDS - 1) begin
                    if (exp_evt == SLOTS - 1) ev64_eof_data = int'(o_data);
                    exp_evt = exp_evt + 1;
                    exp_word = 0;
                    eofs_total = eofs_total + 1;
                end else begin
                    exp_word = exp_word + 1;
                end
            end else if (rd_done) begin
                expect_eq("rd_done_spurious", 32'(rd_done), 32'd0);
            end
            if (mem_rd_en) begin
                issued = issued + 1;
                expect_eq("credit", 32'((issued - accepted) <= FIFO_DEPTH), 32'd1);
            end
            prev_stall = o_valid && !o_ready;
            prev_word  = {o_sof, o_eof, o_data};
        end
    end

    // Downstream ready driver.
    initial begin
        o_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: o_ready = 1'b1;
                1: begin
                    o_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                    rdy_phase++;
                end
                default: o_ready = ($urandom_range(0, 99) < 70);
            endcase
        end
    end

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy && !o_valid && !r_request && posted == q_sub) done = 1;
        end
        if (!done) expect_eq("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #1 live_rising = 1'b1;
        @(posedge clk);
        #1 live_rising = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        expect_eq({tag, "_outs"}, 32'({r_submit, mem_rd_en, o_valid, o_sof, o_eof, rd_done, busy}), 32'd0);
        expect_eq({tag, "_addr"}, 32'(mem_rd_addr), 32'd0);
        expect_eq({tag, "_data"}, 32'(o_data), 32'd0);
        expect_eq({tag, "_cnt"}, 32'(evt_count), 32'd0);
    endtask

    initial begin
        int lat;
        int sub0;
        int eof0;
        bit seen;
        rst_n = 1'b0;
        live_rising = 1'b0;
        r_request = 1'b0;
        @(posedge clk);
        #1 check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1;

        // Single event with o_ready high: latency, count, words.
        rdy_mode = 0;
        @(posedge clk);
        #1 posted = posted + 1;
        @(posedge clk);
        lat = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (o_valid) seen = 1;
            else begin @(posedge clk); lat++; end
        end
        expect_eq("latency", 32'(lat), 32'd5);
        wait_idle(200);
        expect_eq("single_cnt", 32'(evt_count), 32'd1);
        expect_eq("single_submits", 32'(q_sub), 32'd1);
        expect_eq("single_words", 32'(words_total), 32'(EVT_WORDS));

        // Backpressure 1,0,0,1 during one event (uses evt_ptr 1).
        rdy_mode = 1;
        rdy_phase = 0;
        #0 posted = posted + 1;
        wait_idle(400);
        expect_eq("bp_cnt", 32'(evt_count), 32'd2);
        expect_eq("bp_words", 32'(words_total), 32'(2 * EVT_WORDS));

        // Flush in idle then 65 events back to back under random ready: pointer wrap.
        pulse_flush();
        expect_eq("flush_idle_cnt", 32'(evt_count), 32'd0);
        rdy_mode = 2;
        sub0 = q_sub;
        posted = posted + SLOTS + 1;
        wait_idle(8000);
        expect_eq("wrap_cnt", 32'(evt_count), 32'(SLOTS + 1));
        expect_eq("wrap_submits", 32'(q_sub - sub0), 32'(SLOTS + 1));
        expect_eq("wrap_ev64_eof", 32'(ev64_eof_data), 32'h3FF);
        expect_eq("wrap_ev65_sof", 32'(last_sof_data), 32'h000);

        // Flush after 5 accepted words.
        rdy_mode = 0;
        eof0 = eofs_total;
        posted = posted + 1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            if (exp_word >= 5) seen = 1;
        end
        expect_eq("flush_reach5", 32'(seen), 32'd1);
        #1 live_rising = 1'b1;
        @(posedge clk);
        #1 live_rising = 1'b0;
        @(negedge clk);
        expect_eq("flush_valid", 32'(o_valid), 32'd0);
        expect_eq("flush_rd_done", 32'(rd_done), 32'd0);
        wait_idle(100);
        expect_eq("flush_no_eof", 32'(eofs_total - eof0), 32'd0);
        expect_eq("flush_cnt", 32'(evt_count), 32'd0);
        last_sof_data = -1;
        posted = posted + 1;
        wait_idle(200);
        expect_eq("flush_next_addr", 32'(last_sof_data), 32'h000);
        expect_eq("flush_next_cnt", 32'(evt_count), 32'd1);

        // Async reset mid-READ with o_valid high.
        posted = posted + 1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (o_valid) seen = 1;
        end
        expect_eq("rst_reach_valid", 32'(seen), 32'd1);
        expect_eq("rst_in_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        mon_en = 0;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        expect_eq("post_rst_busy", 32'(busy), 32'd0);
        expect_eq("post_rst_valid", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1 mon_en = 1;
        last_sof_data = -1;
        posted = posted + 1;
        wait_idle(200);
        expect_eq("post_rst_addr", 32'(last_sof_data), 32'h000);
        expect_eq("post_rst_cnt", 32'(evt_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
